// File: rtl/seq_cla16_ctrl.sv
// Sequential adder: one 4-bit carry-lookahead slice is reused over NIBBLES passes,
// least-significant nibble first, to add or subtract two W-bit operands.
// Optional feature: define SEQ_CLA_OVF_EN to add the registered signed-overflow output ovf.
module seq_cla16_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   sub,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
`ifdef SEQ_CLA_OVF_EN
    output logic                   cout,
    output logic                   ovf
`else
    output logic                   cout
`endif
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(NIBBLES - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          done_q, done_d;
`ifdef SEQ_CLA_OVF_EN
    logic          ovf_q, ovf_d;
`endif

    // Slice signals; base is the bit offset of the nibble selected by cnt_q.
    logic [CW+1:0] base;
    logic [3:0]    nib_a, nib_b, g, p, c, s;
    logic          c4;

    // The single 4-bit carry-lookahead slice, fed from the current nibble.
    always_comb begin
        base  = {cnt_q, 2'b00};
        nib_a = a_q[base +: 4];
        nib_b = b_q[base +: 4];
        g     = nib_a & nib_b;
        p     = nib_a ^ nib_b;
        c[0]  = carry_q;
        c[1]  = g[0] | (p[0] & c[0]);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c4    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
        s     = p ^ c;
    end

    // Next-state logic for the IDLE/RUN/DONE controller and the datapath registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
`ifdef SEQ_CLA_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    // Subtraction is A + ~B + 1.
                    b_d     = b ^ {W{sub}};
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[base +: 4] = s;
                carry_d          = c4;
                if (cnt_q == LastCnt) begin
                    cout_d  = c4;
`ifdef SEQ_CLA_OVF_EN
                    ovf_d   = c[3] ^ c4;
`endif
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                // done is registered, so the pulse appears on the cycle after DONE.
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SEQ_CLA_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
`ifdef SEQ_CLA_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SEQ_CLA_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_seq_cla16_ctrl.sv
// Self-checking bench for seq_cla16_ctrl (NIBBLES = 4); expected results come from
// plain W+1-bit arithmetic on the operands.
module tb_seq_cla16_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst, start, sub, cin;
    logic [W-1:0] a, b;
    logic         busy, done, cout;
    logic [W-1:0] sum;
`ifdef SEQ_CLA_OVF_EN
    logic         ovf;
`endif

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] prev_sum;

    always #5 clk = ~clk;

    seq_cla16_ctrl #(.NIBBLES(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SEQ_CLA_OVF_EN
        .cout  (cout),
        .ovf   (ovf)
`else
        .cout  (cout)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
    endtask

    // Runs one operation; inject != 0 presents a second start two cycles after acceptance.
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tcin, input logic tsub, input bit inject);
        logic [W-1:0] beff;
        logic [W:0]   full;
        logic         eovf;
        int           n;
        int           extra;
        beff = tsub ? ~tb : tb;
        full = {1'b0, ta} + {1'b0, beff} + {{W{1'b0}}, (tsub ? 1'b1 : tcin)};
        eovf = (ta[W-1] == beff[W-1]) && (full[W-1] != ta[W-1]);
        a = ta; b = tb; cin = tcin; sub = tsub; start = 1'b1;
        step();
        start = 1'b0;
        scramble();
        chk({tag, " busy"}, 32'(busy), 32'd1);
        chk({tag, " done_early"}, 32'(done), 32'd0);
        n = 0;
        while (n < 20) begin
            step();
            n++;
            if (n == 1) chk({tag, " nibble0"}, 32'(sum), 32'({prev_sum[W-1:4], full[3:0]}));
            if (inject && n == 2) begin
                start = 1'b1;
                scramble();
            end
            if (inject && n == 3) start = 1'b0;
            if (done === 1'b1) break;
        end
        chk({tag, " latency"}, 32'(n), 32'(N + 1));
        chk({tag, " sum"}, 32'(sum), 32'(full[W-1:0]));
        chk({tag, " cout"}, 32'(cout), 32'(full[W]));
`ifdef SEQ_CLA_OVF_EN
        chk({tag, " ovf"}, 32'(ovf), 32'(eovf));
`else
        if (eovf && n < 0) $display("unreachable");
`endif
        prev_sum = full[W-1:0];
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done === 1'b1) extra++;
        end
        chk({tag, " single_done"}, 32'(extra), 32'd0);
        chk({tag, " sum_hold"}, 32'(sum), 32'(full[W-1:0]));
        chk({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int dones;
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        prev_sum = '0;
        step();
        step();
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset sum", 32'(sum), 32'd0);
        chk("reset cout", 32'(cout), 32'd0);
        rst = 1'b0;
        step();

        run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
        run_op("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        run_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
        run_op("sub_pos", 16'h0007, 16'h0005, 1'b1, 1'b1, 1'b0);
        run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        run_op("add_cin", 16'h00FF, 16'h0F00, 1'b1, 1'b0, 1'b0);
        run_op("restart_ignored", 16'hABCD, 16'h1111, 1'b0, 1'b0, 1'b1);

        // Abort two cycles into RUN; reset also overrides a simultaneous start.
        a = 16'h8888; b = 16'h9999; cin = 1'b1; sub = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort sum", 32'(sum), 32'd0);
        chk("abort cout", 32'(cout), 32'd0);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done === 1'b1) dones++;
        end
        chk("abort no_done", 32'(dones), 32'd0);
        chk("abort stays_idle", 32'(busy), 32'd0);
        prev_sum = '0;
        run_op("after_abort", 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            run_op("random", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_cla16_ctrl.md
SEQ_CLA16_CTRL -- requirements
Module: seq_cla16_ctrl

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, meaning number of 4-bit slices; operand width W = 4*NIBBLES.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 SHALL have port start  input  1  request to begin an addition; accepted only in IDLE.
REQ-005 SHALL have port sub  input  1  0 = A+B+cin, 1 = A-B (B inverted, carry-in forced 1, cin ignored).
REQ-006 SHALL have port a  input  W  operand A, sampled on the accepting edge.
REQ-007 SHALL have port b  input  W  operand B, sampled on the accepting edge.
REQ-008 SHALL have port cin  input  1  carry-in, sampled on the accepting edge.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port done  output  1  single-cycle pulse, result valid.
REQ-011 SHALL have port sum  output  W  result, registered.
REQ-012 SHALL have port cout  output  1  final carry-out, registered.

Function
REQ-013 SHALL instantiate exactly one 4-bit carry-lookahead adder slice and time-multiplex it over all NIBBLES slices; no other adder logic on the datapath.
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 IDLE: start=1 -> latch a, b^{W{sub}}, carry register <= sub ? 1 : cin, nibble counter <= 0, go RUN; start=0 -> stay IDLE.
REQ-016 RUN: each cycle feed nibble[cnt] of latched A and B plus carry register to the slice; write slice sum into sum[4*cnt+3:4*cnt]; carry register <= slice carry-out; cnt <= cnt+1.
REQ-017 RUN: when cnt = NIBBLES-1, go DONE on same edge and load cout with that slice's carry-out.
REQ-018 DONE: done=1 for exactly one cycle, then go IDLE unconditionally.
REQ-019 Latency: start sampled on edge k -> done high in cycle following edge k+NIBBLES+1 (N+1 edges after acceptance).
REQ-020 busy SHALL be 1 in RUN and DONE, 0 in IDLE.
REQ-021 start while in RUN or DONE SHALL be ignored (no queueing); operands/sub/cin changes after acceptance SHALL not affect the result.
REQ-022 sum and cout SHALL hold their last values in IDLE until the next accepted start; sum nibbles not yet written in RUN hold previous values.
REQ-023 Subtraction result SHALL be two's-complement A-B modulo 2^W; cout=1 means no borrow.
REQ-024 Counter width SHALL be ceil(log2(NIBBLES)), min 1; no wrap beyond NIBBLES-1.

Reset
REQ-025 rst=1 SHALL force state IDLE, cnt 0, carry register 0, sum 0, cout 0, done 0, busy 0 (and ovf 0 when present) on the next rising edge.
REQ-026 rst asserted mid-operation SHALL abort it; no done pulse for the aborted operation; rst has priority over start.

Configuration
REQ-027 Macro SEQ_CLA_OVF_EN SHALL, when defined, add port ovf  output  1  signed overflow, registered with cout, = carry into MSB XOR carry out of MSB of the last slice.
REQ-028 Without SEQ_CLA_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-029 NIBBLES=4, sub=0, a=0x1234, b=0x4321, cin=0 -> done 5 edges after start, sum=0x5555, cout=0.
REQ-030 sub=0, a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry ripples through all 4 passes); ovf=0 if enabled.
REQ-031 sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0; sub=1, a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
REQ-032 SEQ_CLA_OVF_EN defined, a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovf=1, cout=0.
REQ-033 start accepted, second start with different operands 2 cycles later -> ignored, single done, result of first operands only.
REQ-034 rst pulsed 2 cycles into RUN -> busy=0, done never pulses, sum=0, cout=0; next start completes normally.
